icache_ifill_responder: RTL and testbench

- Upper-level responder for the instruction-cache iFill interface: accepts one line-fill request (physical line address plus target way) from the icache.
- Issues one read to the L2/memory port and streams the returned line back to the icache as N_BEATS in-order beats.
- Sits between the icache's ifill request/response ports and the memory-side read channel.
- Handles flush by draining outstanding memory beats without forwarding them.

---
 rtl/icache_ifill_responder.sv | 176 +++++++++++++++++
 tb/tb_icache_ifill_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ifill_responder.sv
// icache_ifill_responder
// Services one icache line fill at a time: latches the request, issues a single
// read on the memory request channel and returns the line as N_BEATS in-order
// beats, one cycle after each memory beat. A flush turns the rest of the line
// into a silent drain so the memory side always completes its burst.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   flush_i                  abort the current fill
//   ifill_req_*              line-fill request (line address, target way)
//   ifill_resp_*             beat valid / last-beat ack / beat index / data / way
//   busy_o                   a fill is in progress
//   mem_req_*                read request to L2/memory (valid/ready handshake)
//   mem_resp_*               returned beats, in order, never back-pressured
//
// Optional feature (macro ICACHE_IFILL_ERR_EN): adds mem_resp_err_i and
// ifill_resp_xcpt_o; an errored beat anywhere in the line raises xcpt on the ack beat.
module icache_ifill_responder #(
    parameter int unsigned PADDR_LINE_W = 26,
    parameter int unsigned WAY_W        = 2,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned N_BEATS      = 4,
    parameter int unsigned BEAT_W       = $clog2(N_BEATS)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_i,
    input  logic                    ifill_req_valid_i,
    input  logic [PADDR_LINE_W-1:0] ifill_req_paddr_i,
    input  logic [WAY_W-1:0]        ifill_req_way_i,
    output logic                    ifill_resp_valid_o,
    output logic                    ifill_resp_ack_o,
    output logic [BEAT_W-1:0]       ifill_resp_beat_o,
    output logic [DATA_W-1:0]       ifill_resp_data_o,
    output logic [WAY_W-1:0]        ifill_resp_way_o,
`ifdef ICACHE_IFILL_ERR_EN
    input  logic                    mem_resp_err_i,
    output logic                    ifill_resp_xcpt_o,
`endif
    output logic                    busy_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [PADDR_LINE_W-1:0] mem_req_addr_o,
    input  logic                    mem_resp_valid_i,
    input  logic [DATA_W-1:0]       mem_resp_data_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [WAY_W-1:0]  way_q;
    logic [BEAT_W-1:0] cnt;
    logic              drop;
    logic              accept;
    logic              handshake;
    logic              beat_in;
    logic              last_in;
    logic              fwd;
`ifdef ICACHE_IFILL_ERR_EN
    logic              err_sticky;
`endif

    // Next-state decode and per-cycle strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        handshake  = 1'b0;
        fwd        = 1'b0;
        beat_in    = mem_resp_valid_i && ((state == S_RESP) || (state == S_DRAIN));
        last_in    = beat_in && (cnt == LAST_BEAT);
        case (state)
            S_IDLE: begin
                if (ifill_req_valid_i && !flush_i) begin
                    accept     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // A flush here never withdraws the request; the line is drained instead.
                if (mem_req_ready_i) begin
                    handshake  = 1'b1;
                    state_next = (drop || flush_i) ? S_DRAIN : S_RESP;
                end
            end
            S_RESP: begin
                // Leave one cycle after the last beat so busy covers the ack beat.
                if (ifill_resp_ack_o) begin
                    state_next = S_IDLE;
                end else if (flush_i) begin
                    state_next = last_in ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid_i) begin
                    fwd = 1'b1;
                end
            end
            S_DRAIN: begin
                if (last_in) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, request latch, beat counter and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= S_IDLE;
            way_q              <= '0;
            cnt                <= '0;
            drop               <= 1'b0;
            busy_o             <= 1'b0;
            mem_req_valid_o    <= 1'b0;
            mem_req_addr_o     <= '0;
            ifill_resp_valid_o <= 1'b0;
            ifill_resp_ack_o   <= 1'b0;
            ifill_resp_beat_o  <= '0;
            ifill_resp_data_o  <= '0;
            ifill_resp_way_o   <= '0;
        end else begin
            state           <= state_next;
            busy_o          <= (state_next != S_IDLE);
            mem_req_valid_o <= (state_next == S_REQ);
            if (accept) begin
                mem_req_addr_o <= ifill_req_paddr_i;
                way_q          <= ifill_req_way_i;
            end
            if (accept) begin
                drop <= 1'b0;
            end else if ((state == S_REQ) && flush_i) begin
                drop <= 1'b1;
            end
            if (handshake) begin
                cnt <= '0;
            end else if (beat_in) begin
                cnt <= cnt + BEAT_W'(1);
            end
            ifill_resp_valid_o <= fwd;
            ifill_resp_ack_o   <= fwd && (cnt == LAST_BEAT);
            if (fwd) begin
                ifill_resp_beat_o <= cnt;
                ifill_resp_data_o <= mem_resp_data_i;
                ifill_resp_way_o  <= way_q;
            end
        end
    end

`ifdef ICACHE_IFILL_ERR_EN
    // Per-line sticky error, reported only alongside the ack beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_sticky        <= 1'b0;
            ifill_resp_xcpt_o <= 1'b0;
        end else begin
            if (accept) begin
                err_sticky <= 1'b0;
            end else if (beat_in && mem_resp_err_i) begin
                err_sticky <= 1'b1;
            end
            ifill_resp_xcpt_o <= fwd && (cnt == LAST_BEAT) && (err_sticky || mem_resp_err_i);
        end
    end
`endif

    // Memory beats are only legal while a line is outstanding.
    mem_beat_outside_fill: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        mem_resp_valid_i |-> ((state == S_RESP) || (state == S_DRAIN))
    );

endmodule

// File: tb/tb_icache_ifill_responder.sv
// Bench for icache_ifill_responder: each fill is planned up front (ready delay,
// beat cycles, flush point, data, errors) and the required per-cycle outputs are
// derived from that plan into cycle-indexed tables, which one compare process
// checks against the DUT on every falling edge.
module tb_icache_ifill_responder;

    localparam int unsigned PW = 26;
    localparam int unsigned WW = 2;
    localparam int unsigned DW = 128;
    localparam int unsigned NB = 4;
    localparam int unsigned BW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_paddr = '0;
    logic [WW-1:0] req_way = '0;
    logic          resp_valid;
    logic          resp_ack;
    logic [BW-1:0] resp_beat;
    logic [DW-1:0] resp_data;
    logic [WW-1:0] resp_way;
    logic          busy;
    logic          mreq_valid;
    logic          mreq_ready = 1'b0;
    logic [PW-1:0] mreq_addr;
    logic          mresp_valid = 1'b0;
    logic [DW-1:0] mresp_data = '0;
    logic          mresp_err = 1'b0;
`ifdef ICACHE_IFILL_ERR_EN
    logic          resp_xcpt;
`endif

    icache_ifill_responder #(
        .PADDR_LINE_W(PW), .WAY_W(WW), .DATA_W(DW), .N_BEATS(NB), .BEAT_W(BW)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rst_n),
        .flush_i            (flush_i),
        .ifill_req_valid_i  (req_valid),
        .ifill_req_paddr_i  (req_paddr),
        .ifill_req_way_i    (req_way),
        .ifill_resp_valid_o (resp_valid),
        .ifill_resp_ack_o   (resp_ack),
        .ifill_resp_beat_o  (resp_beat),
        .ifill_resp_data_o  (resp_data),
        .ifill_resp_way_o   (resp_way),
`ifdef ICACHE_IFILL_ERR_EN
        .mem_resp_err_i     (mresp_err),
        .ifill_resp_xcpt_o  (resp_xcpt),
`endif
        .busy_o             (busy),
        .mem_req_valid_o    (mreq_valid),
        .mem_req_ready_i    (mreq_ready),
        .mem_req_addr_o     (mreq_addr),
        .mem_resp_valid_i   (mresp_valid),
        .mem_resp_data_i    (mresp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Required outputs, keyed by cycle number; absent key means 0 / no beat.
    bit            e_busy[int];
    bit            e_mreq[int];
    logic [PW-1:0] e_addr[int];
    logic [DW-1:0] e_data[int];
    logic [BW-1:0] e_beat[int];
    logic [WW-1:0] e_way[int];
    bit            e_ack[int];
    bit            e_xcpt[int];

    logic [DW-1:0] h_data = '0;
    logic [BW-1:0] h_beat = '0;
    logic [WW-1:0] h_way = '0;
    logic [PW-1:0] h_addr = '0;

    int n_valid = 0;
    int n_ack = 0;
    int n_xcpt = 0;
    int last_ack_cyc = -1;
    int last_rise_cyc = -1;
    bit prev_mreq = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, every output.
    always @(negedge clk) begin
        if (e_data.exists(cyc)) begin
            h_data = e_data[cyc];
            h_beat = e_beat[cyc];
            h_way  = e_way[cyc];
        end
        if (e_addr.exists(cyc)) h_addr = e_addr[cyc];
        chk("resp_valid", 128'(resp_valid), 128'(e_data.exists(cyc)));
        chk("resp_ack",   128'(resp_ack),   128'(e_ack.exists(cyc)));
        chk("busy",       128'(busy),       128'(e_busy.exists(cyc)));
        chk("mem_req",    128'(mreq_valid), 128'(e_mreq.exists(cyc)));
        chk("mem_addr",   128'(mreq_addr),  128'(h_addr));
        chk("resp_data",  resp_data,        h_data);
        chk("resp_beat",  128'(resp_beat),  128'(h_beat));
        chk("resp_way",   128'(resp_way),   128'(h_way));
`ifdef ICACHE_IFILL_ERR_EN
        chk("resp_xcpt",  128'(resp_xcpt),  128'(e_xcpt.exists(cyc) ? e_xcpt[cyc] : 1'b0));
        if (resp_xcpt) n_xcpt++;
`endif
        if (resp_valid) n_valid++;
        if (resp_ack) begin
            n_ack++;
            last_ack_cyc = cyc;
        end
        if (mreq_valid && !prev_mreq) last_rise_cyc = cyc;
        prev_mreq = mreq_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            req_valid   = 1'b0;
            flush_i     = ($urandom_range(3, 0) == 0);
            mreq_ready  = 1'($urandom_range(1, 0));
            mresp_valid = 1'b0;
            mresp_data  = {$urandom, $urandom, $urandom, $urandom};
            mresp_err   = 1'($urandom_range(1, 0));
            step();
        end
    endtask

    // fmode: 0 none, 1 flush in REQ, 2 flush in RESP, 3 flush together with the request in IDLE.
    task automatic fill(input logic [PW-1:0] a, input logic [WW-1:0] w, input int d,
                        input int gmin, input int gmax, input int fmode, input int fsel,
                        input bit b2b, input bit rnd, input logic [3:0] errmask);
        int c0, s, r, f, last, req_last;
        int b[4];
        logic [DW-1:0] dat[4];
        bit dropped, anyerr;
        c0 = cyc;
        s  = (fmode == 3) ? c0 + 2 : c0 + 1;
        r  = s + d;
        for (int i = 0; i < 4; i++) begin
            b[i]   = ((i == 0) ? r + 1 : b[i-1] + 1) + int'($urandom_range(gmax, gmin));
            dat[i] = rnd ? {$urandom, $urandom, $urandom, $urandom} : DW'(32'hD0 + 32'(i));
        end
        f = -1;
        if (fmode == 1) f = s + (fsel % (d + 1));
        if (fmode == 2) f = r + 1 + (fsel % (b[3] - r));
        dropped = (fmode == 1) || (fmode == 2);
        last     = dropped ? b[3] : b[3] + 1;
        req_last = (dropped || !b2b) ? b[3] : b[3] + 1;
        for (int t = s; t <= last; t++) e_busy[t] = 1'b1;
        for (int t = s; t <= r; t++) e_mreq[t] = 1'b1;
        e_addr[s] = a;
        anyerr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            anyerr = anyerr | errmask[i];
            if (!dropped || (fmode == 2 && b[i] < f)) begin
                e_data[b[i] + 1] = dat[i];
                e_beat[b[i] + 1] = BW'(i);
                e_way[b[i] + 1]  = w;
                if (i == 3) begin
                    e_ack[b[i] + 1]  = 1'b1;
                    e_xcpt[b[i] + 1] = anyerr;
                end
            end
        end
        for (int t = c0; t <= last; t++) begin
            req_valid   = (t <= req_last);
            req_paddr   = a;
            req_way     = w;
            flush_i     = (fmode == 3 && t == c0) || (dropped && t == f);
            mreq_ready  = (t == r);
            mresp_valid = 1'b0;
            mresp_data  = {$urandom, $urandom, $urandom, $urandom};
            mresp_err   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (t == b[i]) begin
                    mresp_valid = 1'b1;
                    mresp_data  = dat[i];
                    mresp_err   = errmask[i];
                end
            end
            step();
        end
        req_valid   = 1'b0;
        flush_i     = 1'b0;
        mresp_valid = 1'b0;
    endtask

    initial begin
        int nv0, na0, a1;
        logic [3:0] em;
        repeat (3) step();
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_valid", 128'(resp_valid), 128'(0));
        rst_n = 1'b1;
        step();

        // Basic fill, ready after 3 cycles, back-to-back beats D0..D3.
        nv0 = n_valid; na0 = n_ack;
        fill(26'h123456, 2'd2, 3, 0, 0, 0, 0, 1'b0, 1'b0, 4'b0000);
        chk("basic_nvalid", 128'(n_valid - nv0), 128'(4));
        chk("basic_nack", 128'(n_ack - na0), 128'(1));
        chk("basic_addr", 128'(mreq_addr), 128'(26'h123456));
        chk("basic_last_data", resp_data, 128'hD3);
        idle(2);

        // Gapped beats with 2-cycle bubbles.
        nv0 = n_valid;
        fill(26'h0ABCDE, 2'd1, 1, 2, 2, 0, 0, 1'b0, 1'b1, 4'b0000);
        chk("gapped_nvalid", 128'(n_valid - nv0), 128'(4));
        idle(1);

        // Flush in RESP on the cycle of beat 2, then a new request one cycle later.
        nv0 = n_valid; na0 = n_ack;
        fill(26'h0000F0, 2'd3, 0, 0, 0, 2, 2, 1'b0, 1'b1, 4'b0000);
        chk("flush_resp_nvalid", 128'(n_valid - nv0), 128'(2));
        chk("flush_resp_nack", 128'(n_ack - na0), 128'(0));
        fill(26'h0000F4, 2'd0, 0, 0, 1, 0, 0, 1'b0, 1'b1, 4'b0000);
        idle(2);

        // Flush in REQ with ready delayed 5 cycles.
        nv0 = n_valid;
        fill(26'h155555, 2'd1, 5, 0, 1, 1, 1, 1'b0, 1'b1, 4'b0000);
        chk("flush_req_nvalid", 128'(n_valid - nv0), 128'(0));
        chk("flush_req_idle", 128'(busy), 128'(0));
        idle(2);

        // Back-to-back with request held through ack.
        fill(26'h02AAAA, 2'd2, 0, 0, 1, 0, 0, 1'b1, 1'b1, 4'b0000);
        a1 = last_ack_cyc;
        fill(26'h03BBBB, 2'd3, 2, 0, 0, 0, 0, 1'b0, 1'b1, 4'b0000);
        chk("b2b_gap", 128'(last_rise_cyc - a1), 128'(2));
        idle(2);

`ifdef ICACHE_IFILL_ERR_EN
        na0 = n_xcpt;
        fill(26'h011111, 2'd0, 1, 0, 0, 0, 0, 1'b0, 1'b1, 4'b0010);
        chk("err_line_xcpt", 128'(n_xcpt - na0), 128'(1));
        na0 = n_xcpt;
        fill(26'h022222, 2'd1, 1, 0, 0, 0, 0, 1'b0, 1'b1, 4'b0000);
        chk("clean_line_xcpt", 128'(n_xcpt - na0), 128'(0));
        idle(1);
`endif

        // Randomized fills.
        for (int k = 0; k < 150; k++) begin
            int fm;
            fm = int'($urandom_range(5, 0));
            if (fm > 3) fm = 0;
            for (int i = 0; i < 4; i++) em[i] = ($urandom_range(7, 0) == 0);
            fill(PW'($urandom), WW'($urandom), int'($urandom_range(4, 0)), 0,
                 int'($urandom_range(3, 0)), fm, int'($urandom_range(50, 0)),
                 1'($urandom_range(1, 0)), 1'b1, em);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 0)));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
